uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload.
REQ-005 DATA_VALID  input  1  payload-offer strobe.
REQ-006 PAR_EN  input  1  1 = append parity bit.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 PRESCALE  input  6  CLK cycles per bit period; 0 is treated as 1.
REQ-009 READY  output  1  holding buffer empty; offer accepted this cycle.
REQ-010 BUSY  output  1  frame in progress (state != IDLE).
REQ-011 TX_OUT  output  1  serial line, registered, idles high.

Function
REQ-012 Accept = DATA_VALID && READY at a rising edge: P_DATA, PAR_EN and PAR_TYP written to a one-entry holding buffer; READY deasserts the following cycle.
REQ-013 DATA_VALID while READY=0 is ignored; the buffer is never overwritten.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE with buffer full -> START next edge: shift register, parity config and PRESCALE are loaded from the buffer, the buffer empties, and READY reasserts.
REQ-016 Latency: accept edge at cycle 0 -> TX_OUT low from cycle 2.
REQ-017 START: TX_OUT=0 for one bit period -> DATA.
REQ-018 DATA: DATA_WIDTH bits, LSB first, one bit period each; after the last bit -> PARITY if latched PAR_EN=1, else STOP.
REQ-019 PARITY: TX_OUT = XOR of payload (even) or its inverse (odd), one bit period -> STOP.
REQ-020 STOP: TX_OUT=1 for one bit period; at its end -> START directly (no idle cycle) if the buffer is full, else IDLE.
REQ-021 Bit period = latched PRESCALE cycles; changes to PRESCALE, PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
REQ-022 Bit-period counter is 6 bits; bit counter is wide enough for DATA_WIDTH with no wrap-around inside a frame.
REQ-023 TX_OUT=1 in IDLE and on any unused state encoding; unused states -> IDLE next edge.
REQ-024 A buffer load and a new accept never occur in the same cycle, because READY is 0 while the buffer is full.

Reset
REQ-025 RST=1 at an edge: state IDLE, TX_OUT=1, BUSY=0, READY=1, buffer empty, all counters 0.
REQ-026 Reset mid-frame aborts the frame and discards the buffered word; TX_OUT=1 from the following cycle.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity behaviour is per REQ-018/019.
REQ-028 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic are omitted; PAR_EN and PAR_TYP ports remain but are ignored; frames are always DATA_WIDTH+2 bits.

Verification
REQ-029 PRESCALE=1, PAR_EN=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, then held at 1; BUSY high for 10 cycles.
REQ-030 PRESCALE=1, PAR_EN=1, P_DATA=0x03: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame is 11 bits.
REQ-031 PRESCALE=4, PAR_EN=0, P_DATA=0x00 -> each bit held 4 cycles; BUSY high for 40 cycles; PRESCALE changed to 2 mid-frame has no effect.
REQ-032 0x11 sent, then 0x22 offered while READY=1, then 0x33 offered while READY=0 -> 0x22 frame starts the cycle after the 0x11 stop bit; 0x33 is never transmitted.
REQ-033 RST pulsed during DATA bit 3 with a word buffered -> next cycle TX_OUT=1, BUSY=0, READY=1; no further frame is sent.
REQ-034 Build without UART_TX_PARITY_EN, PAR_EN=1, P_DATA=0xFF -> 10-bit frame with no parity bit.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding a start/data/parity/stop frame engine.
// Define UART_TX_PARITY_EN to build the optional parity bit; without it PAR_EN/PAR_TYP are ignored.
module uart_tx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            PRESCALE,
   output logic                  READY,
   output logic                  BUSY,
   output logic                  TX_OUT
);

   localparam int unsigned PW = 6;
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t                state, state_n;
   logic [PW-1:0]         cnt, cnt_n;
   logic [BW-1:0]         bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic [PW-1:0]         presc, presc_n;
   logic                  buf_full, buf_full_n;
   logic [DATA_WIDTH-1:0] buf_data, buf_data_n;
   logic                  tx_n;
   logic                  load;
   logic                  period_end;

`ifdef UART_TX_PARITY_EN
   logic buf_pe, buf_pe_n;
   logic buf_pt, buf_pt_n;
   logic par_en, par_en_n;
   logic par_bit, par_bit_n;
`else
   logic unused_par;
   assign unused_par = ^{PAR_EN, PAR_TYP};
`endif

   assign period_end = (cnt == (presc - PW'(1)));

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         presc    <= PW'(1);
         buf_full <= 1'b0;
         buf_data <= '0;
         TX_OUT   <= 1'b1;
         BUSY     <= 1'b0;
         READY    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         buf_pe   <= 1'b0;
         buf_pt   <= 1'b0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_n;
         shift    <= shift_n;
         presc    <= presc_n;
         buf_full <= buf_full_n;
         buf_data <= buf_data_n;
         TX_OUT   <= tx_n;
         BUSY     <= (state_n != S_IDLE);
         READY    <= ~buf_full_n;
`ifdef UART_TX_PARITY_EN
         buf_pe   <= buf_pe_n;
         buf_pt   <= buf_pt_n;
         par_en   <= par_en_n;
         par_bit  <= par_bit_n;
`endif
      end
   end

   // Next-state, buffer and serial-line logic
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_n      = bit_cnt;
      shift_n    = shift;
      presc_n    = presc;
      buf_full_n = buf_full;
      buf_data_n = buf_data;
      tx_n       = 1'b1;
      load       = 1'b0;
`ifdef UART_TX_PARITY_EN
      buf_pe_n   = buf_pe;
      buf_pt_n   = buf_pt;
      par_en_n   = par_en;
      par_bit_n  = par_bit;
`endif

      case (state)
         S_IDLE: begin
            if (buf_full) begin
               load    = 1'b1;
               state_n = S_START;
            end
         end
         S_START: begin
            tx_n = 1'b0;
            if (period_end) begin
               cnt_n   = '0;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end
         S_DATA: begin
            tx_n = shift[0];
            if (period_end) begin
               cnt_n   = '0;
               shift_n = shift >> 1;
               if (bit_cnt == LAST_BIT) begin
                  bit_n   = '0;
                  state_n = S_STOP;
`ifdef UART_TX_PARITY_EN
                  if (par_en) state_n = S_PARITY;
`endif
               end else begin
                  bit_n = bit_cnt + BW'(1);
               end
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx_n = par_bit;
            if (period_end) begin
               cnt_n   = '0;
               state_n = S_STOP;
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end
`endif
         S_STOP: begin
            tx_n = 1'b1;
            if (period_end) begin
               cnt_n = '0;
               if (buf_full) begin
                  load    = 1'b1;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Frame configuration is frozen here so mid-frame input changes cannot disturb it
      if (load) begin
         shift_n    = buf_data;
         presc_n    = (PRESCALE == '0) ? PW'(1) : PRESCALE;
         cnt_n      = '0;
         bit_n      = '0;
         buf_full_n = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_n   = buf_pe;
         par_bit_n  = (^buf_data) ^ buf_pt;
`endif
      end

      // Accept only into an empty buffer; load above needs it full, so both never coincide
      if (DATA_VALID && !buf_full) begin
         buf_full_n = 1'b1;
         buf_data_n = P_DATA;
`ifdef UART_TX_PARITY_EN
         buf_pe_n   = PAR_EN;
         buf_pt_n   = PAR_TYP;
`endif
      end
   end

endmodule
